// File: rtl/fp_adder_arbiter.sv
// rtl/fp_adder_arbiter.sv - round-robin arbiter sharing one FP adder among NUM_REQ requesters
// Define FP_ARB_TIMEOUT_EN to add the adder watchdog and sticky err output.

module fp_adder_arbiter #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int NUM_REQ      = 4,
  localparam int W           = EXP_LEN + MANTISSA_LEN + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [W-1:0]         resp_sum,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_start,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_done
`ifdef FP_ARB_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {SYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_gnt;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [W-1:0]         r_resp_sum;
  logic [W-1:0]         r_add_a;
  logic [W-1:0]         r_add_b;
  logic                 r_add_start;
  logic [IW-1:0]        w_gnt;
  logic                 w_found;
  int                   w_idx;

`ifdef FP_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;
  logic       w_timeout;

  assign w_timeout = ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) && (r_wdog == 8'hFF);
  assign err       = r_err;
`endif

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SYNC;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_sum   <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_start  <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      r_wdog       <= 8'h00;
      r_err        <= 1'b0;
`endif
    end else begin
      r_req_ready <= '0;
      r_add_start <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      if (r_state == ISSUE)
        r_wdog <= 8'h00;
      else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
        r_wdog <= r_wdog + 8'h01;
      if (w_timeout) begin
        r_state <= SYNC;
        r_err   <= 1'b1;
      end else
`endif
      case (r_state)
        // Drain any result left in flight by a reset before taking new work.
        SYNC: if (add_done) r_state <= IDLE;
        IDLE: begin
          if (w_found) begin
            r_gnt       <= w_gnt;
            r_req_ready <= NUM_REQ'(1) << w_gnt;
            r_add_a     <= req_a[int'(w_gnt)*W +: W];
            r_add_b     <= req_b[int'(w_gnt)*W +: W];
            r_add_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE:     r_state <= WAIT_BUSY;
        WAIT_BUSY: if (!add_done) r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (add_done) begin
            r_resp_sum   <= add_sum;
            r_resp_valid <= NUM_REQ'(1) << r_gnt;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[r_gnt]) begin
            r_resp_valid <= '0;
            r_ptr        <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + IW'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_start  = r_add_start;

endmodule

// File: doc/fp_adder_arbiter.md
FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

Interface
REQ-001 SHALL have parameter EXP_LEN, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_LEN, default 23, stored mantissa width; W = EXP_LEN+MANTISSA_LEN+1.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  requester i has an operand pair pending.
REQ-007 SHALL have port req_a  input  NUM_REQ*W  operand A for requester i, in slice [i*W +: W].
REQ-008 SHALL have port req_b  input  NUM_REQ*W  operand B for requester i, in slice [i*W +: W].
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-010 SHALL have port resp_valid  output  NUM_REQ  one-hot result-valid to the owning requester.
REQ-011 SHALL have port resp_ready  input  NUM_REQ  requester i accepts its result.
REQ-012 SHALL have port resp_sum  output  W  result word, valid while any resp_valid bit is high.
REQ-013 SHALL have port add_a, add_b  output  W each  operands driven to the shared adder.
REQ-014 SHALL have port add_start  output  1  drives the adder's inp_data_ready.
REQ-015 SHALL have port add_sum  input  W  adder result.
REQ-016 SHALL have port add_done  input  1  adder's sum_ready: high when idle/done, low while busy.

Function
REQ-017 SHALL implement FSM states SYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 SHALL leave SYNC for IDLE on the first cycle add_done=1, so a result still in flight in the adder is discarded.
REQ-019 In IDLE with any req_valid high, SHALL grant round-robin starting at pointer ptr, pulse req_ready[g] for that cycle, latch req_a/req_b slice g into add_a/add_b, and go to ISSUE.
REQ-020 In ISSUE, SHALL assert add_start for exactly one cycle and go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, SHALL go to WAIT_DONE when add_done=0, holding add_start low.
REQ-022 In WAIT_DONE, SHALL capture add_sum into resp_sum and go to RESP when add_done=1.
REQ-023 In RESP, SHALL hold resp_valid[g]=1 and resp_sum stable until resp_ready[g]=1. On that edge it SHALL clear resp_valid, set ptr=(g+1) mod NUM_REQ and return to IDLE.
REQ-024 add_a/add_b SHALL remain stable from ISSUE through RESP exit.
REQ-025 resp_ready bits of non-granted requesters and req_valid changes outside IDLE SHALL be ignored.
REQ-026 Minimum grant-to-resp_valid latency SHALL be 3 cycles plus the adder busy time. No overlap is allowed: one operation is outstanding at a time.
REQ-027 A requester holding req_valid continuously SHALL be re-granted no sooner than after every other valid requester has been served once.

Reset
REQ-028 On rst=1, asynchronously: state=SYNC, ptr=0, req_ready=0, resp_valid=0, resp_sum=0, add_a=0, add_b=0, add_start=0, err (if present)=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no response. The requester must re-present it.

Configuration
REQ-030 With macro FP_ARB_TIMEOUT_EN defined, SHALL add output port err (1 bit) and an 8-bit watchdog cleared on entry to WAIT_BUSY.
REQ-031 With FP_ARB_TIMEOUT_EN, if the watchdog reaches 255 in WAIT_BUSY or WAIT_DONE, the block SHALL:
- go to SYNC;
- set err=1, sticky until rst;
- leave the requester with no response.
REQ-032 Without FP_ARB_TIMEOUT_EN, no err port and no watchdog SHALL exist. The block SHALL wait indefinitely.

Verification
REQ-033 Single requester: req 0 with a=0x3F800000, b=0x40000000 -> req_ready[0] pulses once, add_start one cycle, resp_sum=0x40400000 on resp_valid[0].
REQ-034 Simultaneous req_valid=4'b1111 after reset -> grants in order 0,1,2,3. With all requesters held valid, the fifth grant goes to 0.
REQ-035 Backpressure: resp_ready[2] low 10 cycles -> resp_valid[2] and resp_sum stable for 10 cycles, no new grant issued.
REQ-036 Reset during WAIT_DONE while the adder is busy -> no resp_valid, FSM stays in SYNC until add_done=1, then serves a new request correctly.
REQ-037 FP_ARB_TIMEOUT_EN defined, add_done held low after start -> err=1 at watchdog 255, FSM back in SYNC, resp_valid never set.
